imem_loader: RTL

//  Byte-stream boot loader that writes the word-addressed instruction memory at runtime instead of a

---
 rtl/imem_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream packed into 32-bit instruction memory writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, core released
// LEN0  | expecting word count low byte
// LEN1  | expecting word count high byte, range check
// DATA  | collecting bytes of the current word
// WRITE | one-cycle memory write of the packed word
// CSUM  | expecting checksum byte (checksum build only)
// DONE  | load finished OK
// ERR   | load aborted
module imem_loader #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR} state_t;
`else
   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;
`endif

   localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       word_q, word_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [15:0]       n_full;
   logic              last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   assign n_full    = {in_data, len_q[7:0]};
   assign last_word = (16'(idx_q) == (len_q - 16'd1));

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = err_q;
      in_ready = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LEN0;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               idx_d   = '0;
               cnt_d   = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         LEN0: begin
            in_ready = 1'b1;
            if (in_valid) begin
               len_d[7:0] = in_data;
               state_d    = LEN1;
            end
         end
         LEN1: begin
            in_ready = 1'b1;
            if (in_valid) begin
               len_d[15:8] = in_data;
               if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = CSUM;
`else
                  state_d = DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
`endif
               end else if (n_full > 16'(DEPTH)) begin
                  state_d = ERR;
                  err_d   = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            in_ready = 1'b1;
            if (in_valid) begin
               word_d[8*cnt_q +: 8] = in_data;
               cnt_d = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ in_data;
`endif
               if (cnt_q == 2'd3) begin
                  we_d    = 1'b1;
                  waddr_d = idx_q;
                  wdata_d = word_d;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            idx_d = idx_q + IDX_ONE;
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = CSUM;
`else
               state_d = DONE;
               done_d  = 1'b1;
               hold_d  = 1'b0;
`endif
            end else begin
               state_d = DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            in_ready = 1'b1;
            if (in_valid) begin
               hold_d = 1'b0;
               if (in_data == csum_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_d = IDLE;
            hold_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= 16'd0;
         idx_q   <= '0;
         cnt_q   <= 2'd0;
         word_q  <= 32'd0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= 32'd0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign we       = we_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign cpu_hold = hold_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule
